fetch_data_mem_arbiter: RTL
===========================

Name: fetch_data_mem_arbiter

Overview:
Shares one unified mem_system port between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Data side has priority, since its instruction is older in the pipeline.
- A starvation counter guarantees forward progress for fetch.
- Produces per-side stall/done signals that feed the existing PC-hold and pipeline-stall logic.

Parameters:
STARVE_LIMIT, 3, consecutive data grants allowed while fetch is waiting before fetch is forced to win
CNT_W, 2, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT

Ports:
clk  in  1  system clock, all flops rising-edge
rst  in  1  asynchronous active-low reset (0 = reset asserted)
i_rd  in  1  fetch read request, held until i_done
i_addr  in  16  fetch address (PC)
i_data  out  16  instruction returned
i_stall  out  1  fetch must hold PC and request
i_done  out  1  one-cycle pulse, i_data valid
d_rd  in  1  data read request, held until d_done
d_wr  in  1  data write request, held until d_done; d_rd&d_wr is illegal
d_addr  in  16  data address
d_wdata  in  16  write data
d_rdata  out  16  read data returned
d_stall  out  1  memory stage must hold
d_done  out  1  one-cycle pulse, d_rdata valid (reads)
m_rd, m_wr  out  1  shared memory read/write strobes
m_addr  out  16  shared memory address
m_wdata  out  16  shared memory write data
m_rdata  in  16  shared memory read data
m_stall  in  1  shared memory busy
m_done  in  1  shared memory transaction complete
m_err  in  1  shared memory error
err  out  1  sticky error flag

Behaviour:
- Reset (rst=0, any time, including mid-transaction):
  - state=IDLE, starve counter=0, captured addr/wdata=0, err=0.
  - All outputs 0 except i_stall/d_stall, which follow the requests combinationally.
  - An in-flight memory transaction is abandoned and is not replayed.
- States: IDLE, I_BUSY, D_BUSY.
- IDLE:
  - If any request is present, pick a winner:
    - data wins, unless i_rd=1 and starve_cnt>=STARVE_LIMIT, in which case fetch wins;
    - with only one requester, that requester wins.
  - Drive m_* combinationally from the winner in the same cycle (zero-cycle issue) and capture its addr/wdata/op.
  - If m_done in the same cycle (cache hit): pulse the winner's done, stay IDLE.
  - Otherwise go to I_BUSY or D_BUSY.
- I_BUSY / D_BUSY:
  - Drive m_* from the captured registers; the requester's inputs are ignored until completion.
  - On m_done: pulse done, route m_rdata to i_data or d_rdata, return to IDLE.
  - The next arbitration occurs in that IDLE cycle, giving one bubble between back-to-back grants.
- Stalls:
  - i_stall = i_rd & ~i_done.
  - d_stall = (d_rd|d_wr) & ~d_done.
  - The loser of a simultaneous request sees its stall asserted for the whole transaction.
- Starve counter:
  - +1 on each data grant while i_rd=1.
  - Saturates at 2^CNT_W-1.
  - Clears on every fetch grant, and on any cycle with i_rd=0.
- i_data and d_rdata are registered and hold their last value between dones.
- err is set when m_err=1 coincides with m_done, and is cleared only by reset.
- m_rd/m_wr are never both 1, and are 0 in IDLE with no request.

Optional Feature:
ARB_PERF_CNT_EN
- Defined:
  - Adds outputs conflict_cnt[15:0] and starve_evt_cnt[15:0].
  - conflict_cnt increments on each IDLE cycle where both sides request.
  - starve_evt_cnt increments on each forced fetch grant.
  - Both wrap at 16 bits and reset to 0.
- Undefined: the ports and counters are absent; arbitration behaviour is identical.

Decomposition:
- Shared package: the state encoding (IDLE=2'd0, I_BUSY=2'd1, D_BUSY=2'd2) and the owner constants OWN_I/OWN_D.
- Sub-module arb_starve_counter (saturating CNT_W counter with inc/clr and a ge-limit compare). It is natural because the same fairness counter is reused for future multi-requester arbitration.

Test Plan:
- i_rd=1 alone, i_addr=16'h0040, m_done after 3 cycles with m_rdata=16'hA5A5 -> i_stall=1 for 3 cycles, then i_done pulse, i_data=16'hA5A5.
- i_rd and d_wr both asserted in IDLE, d_addr=16'h0100, d_wdata=16'h1234 -> m_wr=1, m_addr=16'h0100 first; fetch granted only after d_done.
- STARVE_LIMIT=3, fetch held, 4 back-to-back data requests -> three data grants, then fetch granted before the 4th data request.
- m_done in the issue cycle (hit) for a data read with m_rdata=16'h00FF -> d_done the same cycle, state stays IDLE, d_rdata=16'h00FF.
- rst driven low mid-D_BUSY -> m_rd/m_wr drop to 0 asynchronously; after release, a pending i_rd is granted first; d_done never pulses for the abandoned access.
- m_err=1 with m_done on a fetch -> err=1 and stays 1 through later clean transactions until reset.

Source files
------------

// File: rtl/fetch_data_mem_arbiter_pkg.sv
// Shared types for the fetch/data unified memory-port arbiter.
package fetch_data_mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_e;

    typedef logic arb_owner_t;
    localparam arb_owner_t OWN_I = 1'b0;
    localparam arb_owner_t OWN_D = 1'b1;

    // Request captured at grant time and replayed on the memory port until done.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating fairness counter with increment/clear and a ge-limit compare.
module arb_starve_counter #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned LIMIT = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic ge_limit_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear dominates increment; increment saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ge_limit_o = (cnt_q >= CNT_W'(LIMIT));

endmodule

// File: rtl/fetch_data_mem_arbiter.sv
// Arbitrates one shared memory port between fetch and data stages, data first with starvation guard.
// Define ARB_PERF_CNT_EN to add the conflict_cnt / starve_evt_cnt performance counters.
module fetch_data_mem_arbiter
    import fetch_data_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned CNT_W        = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data,
    output logic              i_stall,
    output logic              i_done,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              d_done,
    output logic              m_rd,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_stall,
    input  logic              m_done,
    input  logic              m_err,
    output logic              err
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       starve_evt_cnt
`endif
);

    arb_state_e        state_q, state_d;
    mem_req_t          req_q, req_d;
    arb_owner_t        owner;
    logic              d_req;
    logic              grant_i, grant_d, xfer_done, starve_ge;
    logic [DATA_W-1:0] i_data_q, d_rdata_q;
    logic              err_q;

    assign d_req = d_rd | d_wr;

    // Memory busy is implied by the absence of m_done; the strobe is simply held.
    logic unused_ok;
    assign unused_ok = m_stall;

    arb_starve_counter #(
        .CNT_W (CNT_W),
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst_n      (rst),
        .inc_i      (grant_d & i_rd),
        .clr_i      (~i_rd | grant_i),
        .ge_limit_o (starve_ge)
    );

    // Next state, zero-cycle issue from IDLE, replay of the captured request while busy.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        owner     = OWN_I;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        xfer_done = 1'b0;
        m_rd      = 1'b0;
        m_wr      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (i_rd || d_req) begin
                        owner   = (d_req && !(i_rd && starve_ge)) ? OWN_D : OWN_I;
                        grant_i = (owner == OWN_I);
                        grant_d = (owner == OWN_D);
                        if (grant_d) begin
                            req_d = '{wr: d_wr, addr: d_addr, wdata: d_wdata};
                        end else begin
                            req_d = '{wr: 1'b0, addr: i_addr, wdata: '0};
                        end
                        m_rd    = ~req_d.wr;
                        m_wr    = req_d.wr;
                        m_addr  = req_d.addr;
                        m_wdata = req_d.wdata;
                        if (m_done) begin
                            xfer_done = 1'b1;
                            i_done    = grant_i;
                            d_done    = grant_d;
                        end else begin
                            state_d = grant_d ? D_BUSY : I_BUSY;
                        end
                    end
                end
                I_BUSY: begin
                    m_rd   = 1'b1;
                    m_addr = req_q.addr;
                    if (m_done) begin
                        xfer_done = 1'b1;
                        i_done    = 1'b1;
                        state_d   = IDLE;
                    end
                end
                D_BUSY: begin
                    m_rd    = ~req_q.wr;
                    m_wr    = req_q.wr;
                    m_addr  = req_q.addr;
                    m_wdata = req_q.wdata;
                    if (m_done) begin
                        xfer_done = 1'b1;
                        d_done    = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            if (i_done) begin
                i_data_q <= m_rdata;
            end
            if (d_done && !m_wr) begin
                d_rdata_q <= m_rdata;
            end
            if (m_err && xfer_done) begin
                err_q <= 1'b1;
            end
        end
    end

    assign i_data  = i_data_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;
    assign i_stall = i_rd & ~i_done;
    assign d_stall = d_req & ~d_done;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] conflict_q, starve_evt_q;

    // Conflicts are counted per arbitration cycle; forced grants are fetch wins over a live data request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_q   <= '0;
            starve_evt_q <= '0;
        end else begin
            if ((state_q == IDLE) && i_rd && d_req) begin
                conflict_q <= conflict_q + 16'd1;
            end
            if (grant_i && d_req && starve_ge) begin
                starve_evt_q <= starve_evt_q + 16'd1;
            end
        end
    end

    assign conflict_cnt   = conflict_q;
    assign starve_evt_cnt = starve_evt_q;
`endif

endmodule
